mult_share_arbiter: RTL and testbench

- Shares one pipelined signed fixed-point multiplier among NUM_REQ requesters, such as depthwise/pointwise PE lanes and the BN scale path.
- A round-robin arbiter grants at most one operand pair per cycle. A 2-stage multiply pipeline returns the Q-format product tagged with the originating requester ID.
- Supports output backpressure and reports pipeline occupancy to the layer controller.

---
 rtl/mult_share_arbiter.sv | 129 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 2-stage signed Q-format multiplier among NUM_REQ requesters.
// Products leave in grant order, tagged with the requester ID, and stall as a whole under backpressure.
module mult_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int DATA_SIZE = 16,
  parameter int QUAN_SIZE = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_b,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic signed [DATA_SIZE-1:0]    out_data,
  output logic [ID_W-1:0]                out_id,
  input  logic                           out_ready,
  output logic                           busy
);

  // Keep the Q-format window of the full product: floor toward -inf, overflow wraps.
  function automatic logic signed [DATA_SIZE-1:0] trunc_q(
    input logic signed [2*DATA_SIZE-1:0] prod
  );
    return prod[QUAN_SIZE+DATA_SIZE-1:QUAN_SIZE];
  endfunction

  logic [ID_W-1:0]                ptr_q, ptr_d;
  logic                           adv;
  logic                           gnt_found;
  logic [ID_W-1:0]                gnt_idx;
  logic [ID_W-1:0]                cand;
  logic [NUM_REQ-1:0]             grant;

  logic                           vld_p1_q, vld_p1_d;
  logic signed [DATA_SIZE-1:0]    a_p1_q, a_p1_d;
  logic signed [DATA_SIZE-1:0]    b_p1_q, b_p1_d;
  logic [ID_W-1:0]                id_p1_q, id_p1_d;
  logic signed [2*DATA_SIZE-1:0]  prod_p1;

  logic                           vld_p2_q, vld_p2_d;
  logic signed [DATA_SIZE-1:0]    data_p2_q, data_p2_d;
  logic [ID_W-1:0]                id_p2_q, id_p2_d;

  assign adv = !vld_p2_q || out_ready;

  // Grant search starts at the pointer and wraps; it looks only at valids, never at operands.
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (adv && rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!gnt_found && req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_found) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_found) ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Stage 1: capture the granted operand pair
  always_comb begin
    vld_p1_d = vld_p1_q;
    a_p1_d   = a_p1_q;
    b_p1_d   = b_p1_q;
    id_p1_d  = id_p1_q;
    if (adv) begin
      vld_p1_d = gnt_found;
      a_p1_d   = req_a[gnt_idx*DATA_SIZE +: DATA_SIZE];
      b_p1_d   = req_b[gnt_idx*DATA_SIZE +: DATA_SIZE];
      id_p1_d  = gnt_idx;
    end
  end

  assign prod_p1 = (2*DATA_SIZE)'(a_p1_q) * (2*DATA_SIZE)'(b_p1_q);

  // Stage 2: multiply and truncate into the output register
  always_comb begin
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    id_p2_d   = id_p2_q;
    if (adv) begin
      vld_p2_d  = vld_p1_q;
      data_p2_d = trunc_q(prod_p1);
      id_p2_d   = id_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      id_p2_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      id_p2_q   <= id_p2_d;
    end
  end

  // Stage-1 operands are qualified by vld_p1_q, so they need no reset.
  always_ff @(posedge clk) begin
    a_p1_q  <= a_p1_d;
    b_p1_q  <= b_p1_d;
    id_p1_q <= id_p1_d;
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_id    = id_p2_q;
  assign busy      = vld_p1_q || vld_p2_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized bench for mult_share_arbiter: a queue-based reference model predicts grants,
// products and ordering; directed sections cover reset, Q8.8 cases, round robin and stalls.
`timescale 1ns/1ps
module tb_mult_share_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_a, req_b;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic [1:0]         out_id;
  logic               out_ready;
  logic               busy;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(2), .DATA_SIZE(W), .QUAN_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_ready(out_ready), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Q8.8 product: exact product, floor-divided by 256, low 16 bits kept.
  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> 8;
    return p[15:0];
  endfunction

  typedef struct { logic [1:0] id; logic [15:0] d; } item_t;
  item_t      sb[$];
  int         m_ptr = 0;
  bit         mon_en = 0;
  logic [3:0] hs_mask = '0;
  int         hs_cnt = 0;
  int         pop_cnt = 0;
  bit         pstall = 0;
  logic [15:0] pd;
  logic [1:0]  pid;

  task automatic mon_step();
    logic [3:0] exp_g;
    int g;
    item_t it;
    exp_g = '0;
    g = -1;
    if (!out_valid || out_ready) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    if (g >= 0) exp_g[g] = 1'b1;
    chk("grant", req_ready, exp_g);
    chk("busy", busy, sb.size() != 0);
    if (pstall) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_data", out_data, pd);
      chk("hold_id", out_id, pid);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("extra_out", out_valid, 0);
      else begin
        it = sb.pop_front();
        chk("out_id", out_id, it.id);
        chk("out_data", out_data, it.d);
        pop_cnt++;
      end
    end
    hs_mask = exp_g;
    if (g >= 0) begin
      it.id = 2'(g);
      it.d  = qmul(req_a[g*W +: W], req_b[g*W +: W]);
      sb.push_back(it);
      m_ptr = (g + 1) % N;
      hs_cnt++;
    end
    pstall = out_valid && !out_ready;
    pd  = out_data;
    pid = out_id;
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) mon_step();
    else begin
      hs_mask = '0;
      pstall  = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [15:0] a, input logic [15:0] b);
    req_valid[i]   = v;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // Requesters hold valid and operands until granted; idle ones may raise a new request.
  task automatic rand_step(input logic [3:0] allow, input bit keep);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && !hs_mask[i]) continue;
      set_req(i, allow[i] && (keep || $urandom_range(0, 1) == 1), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((req_valid != '0 || busy) && n < 50) begin
      rand_step(4'b0000, 1'b0);
      tick();
      n++;
    end
    chk("drain_done", n < 50, 1);
  endtask

  task automatic single(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
    set_req(2, 1'b1, a, b);
    tick();
    chk("q_hs", hs_mask, 4'b0100);
    set_req(2, 1'b0, 16'h0, 16'h0);
    chk("q_busy1", busy, 1);
    chk("q_vld1", out_valid, 0);
    tick();
    chk("q_vld2", out_valid, 1);
    chk("q_data", out_data, exp);
    chk("q_id", out_id, 2);
    tick();
  endtask

  initial begin
    int start;
    logic [3:0] prev;
    int base_h, base_p;
    bit stalled;
    logic [15:0] pd_s;
    logic [1:0] pid_s;

    rst_n = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    out_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_ready", req_ready, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    rst_n = 1'b1;
    m_ptr = 0;
    mon_en = 1;
    @(negedge clk);
    #1;
    chk("first_gnt", req_ready, 4'b0001);
    tick();
    drain();

    single(16'h0180, 16'h0200, 16'h0300);
    single(16'hFF00, 16'h0080, 16'hFF80);
    single(16'h0001, 16'h0001, 16'h0000);
    single(16'h7F00, 16'h0200, 16'hFE00);
    drain();

    start = m_ptr;
    for (int k = 0; k < 12; k++) begin
      rand_step(4'b1111, 1'b1);
      tick();
      chk("rr_gnt", hs_mask, 1 << ((start + k) % N));
      if (k >= 1) chk("rr_vld", out_valid, 1);
    end
    drain();

    prev = '0;
    for (int k = 0; k < 8; k++) begin
      rand_step(4'b1010, 1'b1);
      tick();
      chk("alt_gnt", (hs_mask == 4'b0010 || hs_mask == 4'b1000) && (k == 0 || hs_mask != prev), 1);
      prev = hs_mask;
    end
    drain();

    base_h = hs_cnt;
    base_p = pop_cnt;
    stalled = 0;
    for (int c = 0; c < 40 && (pop_cnt - base_p) < 4; c++) begin
      if (hs_cnt - base_h < 4) rand_step(4'b0001, 1'b1);
      else rand_step(4'b0000, 1'b0);
      if (!stalled && out_valid && (pop_cnt - base_p) == 1) begin
        stalled = 1;
        out_ready = 1'b0;
        pd_s = out_data;
        pid_s = out_id;
        repeat (3) begin
          tick();
          chk("bp_vld", out_valid, 1);
          chk("bp_data", out_data, pd_s);
          chk("bp_id", out_id, pid_s);
          chk("bp_ready", req_ready, 0);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    chk("bp_count", pop_cnt - base_p, 4);
    chk("bp_stalled", stalled, 1);
    drain();

    for (int k = 0; k < 3; k++) begin
      rand_step(4'b1111, 1'b1);
      tick();
    end
    #3;
    rst_n = 1'b0;
    mon_en = 0;
    sb.delete();
    m_ptr = 0;
    #1;
    chk("mr_vld", out_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", req_ready, 0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    mon_en = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_stale_vld", out_valid, 0);
      chk("mr_stale_busy", busy, 0);
    end
    rand_step(4'b1111, 1'b1);
    @(negedge clk);
    #1;
    chk("mr_ptr", req_ready, 4'b0001);
    tick();
    drain();

    out_ready = 1'b1;
    repeat (200) begin
      rand_step(4'b1111, 1'b0);
      tick();
    end
    repeat (300) begin
      rand_step(4'b1111, 1'b0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
